// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper/checker.
package tt_sweep_pkg;

    localparam int unsigned N_IN       = 7;
    localparam int unsigned N_MINTERMS = 128;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } tt_state_e;

endpackage

// File: rtl/idx_delay_line.sv
// Delays a valid flag and minterm index by Depth cycles so captures line up with FUT latency.
module idx_delay_line #(
    parameter int unsigned Depth = 0,
    parameter int unsigned IdxW  = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [IdxW-1:0] idx_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o
);

    if (Depth == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign valid_o        = valid_i;
        assign idx_o          = idx_i;
    end else begin : g_pipe
        logic [Depth-1:0]           valid_q, valid_d;
        logic [Depth-1:0][IdxW-1:0] idx_q, idx_d;

        always_comb begin
            valid_d    = valid_q;
            idx_d      = idx_q;
            valid_d[0] = valid_i;
            idx_d[0]   = idx_i;
            for (int s = 1; s < Depth; s++) begin
                valid_d[s] = valid_q[s-1];
                idx_d[s]   = idx_q[s-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q <= '0;
                idx_q   <= '0;
            end else begin
                valid_q <= valid_d;
                idx_q   <= idx_d;
            end
        end

        assign valid_o = valid_q[Depth-1];
        assign idx_o   = idx_q[Depth-1];
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives all 128 minterms into a 7-input FUT, captures its truth table and compares it
// against an expected signature, reporting pass, mismatch count and first failing minterm.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter logic [127:0] EXP_TT  = 128'heaeaeaa8eaaae8a8eae8aaa8eaa8a8a8,
    parameter int unsigned  FUT_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [N_IN-1:0]       x,
    input  logic                  f_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_MINTERMS-1:0] tt,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [N_IN-1:0]       first_fail_idx
);

    localparam logic [N_IN-1:0] LastIdx   = N_IN'(N_MINTERMS - 1);
    localparam logic [1:0]      DrainLast = 2'((FUT_LAT == 0) ? 0 : FUT_LAT - 1);

    tt_state_e             state_q, state_d;
    logic [N_IN-1:0]       idx_q, idx_d;
    logic [1:0]            drain_cnt_q, drain_cnt_d;
    logic [N_MINTERMS-1:0] tt_q, tt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_IN-1:0]       ffi_q, ffi_d;
    logic                  pass_q, pass_d;

    logic                  sweep_valid;
    logic                  cap_valid;
    logic [N_IN-1:0]       cap_idx;

    idx_delay_line #(
        .Depth(FUT_LAT),
        .IdxW (N_IN)
    ) u_idx_delay_line (
        .clk_i  (clk),
        .rst_i  (rst),
        .valid_i(sweep_valid),
        .idx_i  (idx_q),
        .valid_o(cap_valid),
        .idx_o  (cap_idx)
    );

    assign sweep_valid = (state_q == SWEEP);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_cnt_d = drain_cnt_q;
        tt_d        = tt_q;
        cnt_d       = cnt_q;
        ffi_d       = ffi_q;
        pass_d      = pass_q;
        busy        = 1'b0;
        done        = 1'b0;

        if (cap_valid) begin
            tt_d[cap_idx] = f_in;
            if (f_in != EXP_TT[cap_idx]) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '0) begin
                    ffi_d = cap_idx;
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    tt_d    = '0;
                    cnt_d   = '0;
                    ffi_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (idx_q == LastIdx) begin
                    drain_cnt_d = '0;
                    if (FUT_LAT > 0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q + N_IN'(1);
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt_q == DrainLast) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The final capture lands on the same edge as DONE entry, so judge on the next count.
        if (state_d == DONE && state_q != DONE) begin
            pass_d = (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            tt_q        <= '0;
            cnt_q       <= '0;
            ffi_q       <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_cnt_q <= drain_cnt_d;
            tt_q        <= tt_d;
            cnt_q       <= cnt_d;
            ffi_q       <= ffi_d;
            pass_q      <= pass_d;
        end
    end

    assign x              = idx_q;
    assign pass           = pass_q;
    assign tt             = tt_q;
    assign mismatch_cnt   = cnt_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: two checkers (combinational FUT and 2-register FUT) with fault injection.
module tb_tt_sweep_checker;

    localparam logic [127:0] ExpTt = 128'heaeaeaa8eaaae8a8eae8aaa8eaa8a8a8;

    typedef struct {
        logic [127:0] tt_v;
        int           cnt;
        int           ffi;
        logic         pass;
        int           done_at;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst0, rst2, start0, start2;
    logic [6:0]   x0, x2, ffi0, ffi2;
    logic         f0, f2, busy0, busy2, done0, done2, pass0, pass2;
    logic [127:0] tt0, tt2;
    logic [7:0]   cnt0, cnt2;
    logic         r1, r2;

    int  fault0   = 0;
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    sb_t q0[$];
    sb_t q2[$];
    sb_t e0m, e2m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational FUT with optional faults: 1 = stuck at 0, 2 = inverted at minterm 127.
    always_comb begin
        f0 = ExpTt[x0];
        if (fault0 == 1) f0 = 1'b0;
        if (fault0 == 2 && x0 == 7'd127) f0 = ~ExpTt[x0];
    end

    always @(posedge clk) begin
        r1 <= ExpTt[x2];
        r2 <= r1;
    end
    assign f2 = r2;

    tt_sweep_checker u_dut0 (
        .clk           (clk),
        .rst           (rst0),
        .start         (start0),
        .x             (x0),
        .f_in          (f0),
        .busy          (busy0),
        .done          (done0),
        .pass          (pass0),
        .tt            (tt0),
        .mismatch_cnt  (cnt0),
        .first_fail_idx(ffi0)
    );

    tt_sweep_checker #(
        .EXP_TT (ExpTt),
        .FUT_LAT(2)
    ) u_dut2 (
        .clk           (clk),
        .rst           (rst2),
        .start         (start2),
        .x             (x2),
        .f_in          (f2),
        .busy          (busy2),
        .done          (done2),
        .pass          (pass2),
        .tt            (tt2),
        .mismatch_cnt  (cnt2),
        .first_fail_idx(ffi2)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic sb_t model(input int mode, input int done_at);
        sb_t          e;
        logic [127:0] g;
        logic         b;
        g      = ExpTt;
        e.tt_v = '0;
        e.cnt  = 0;
        e.ffi  = 0;
        for (int i = 0; i < 128; i++) begin
            b = g[i];
            if (mode == 1) b = 1'b0;
            if (mode == 2 && i == 127) b = ~g[i];
            e.tt_v[i] = b;
            if (b != g[i]) begin
                if (e.cnt == 0) e.ffi = i;
                e.cnt++;
            end
        end
        e.pass    = (e.cnt == 0);
        e.done_at = done_at;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                check_eq("dut0 done with empty scoreboard", 128'(q0.size()), 128'd1);
            end else begin
                e0m = q0.pop_front();
                check_eq("dut0 done cycle", 128'(cyc), 128'(e0m.done_at));
                check_eq("dut0 tt", tt0, e0m.tt_v);
                check_eq("dut0 mismatch_cnt", 128'(cnt0), 128'(e0m.cnt));
                check_eq("dut0 first_fail_idx", 128'(ffi0), 128'(e0m.ffi));
                check_eq("dut0 pass", 128'(pass0), 128'(e0m.pass));
            end
        end
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                check_eq("dut2 done with empty scoreboard", 128'(q2.size()), 128'd1);
            end else begin
                e2m = q2.pop_front();
                check_eq("dut2 done cycle", 128'(cyc), 128'(e2m.done_at));
                check_eq("dut2 tt", tt2, e2m.tt_v);
                check_eq("dut2 mismatch_cnt", 128'(cnt2), 128'(e2m.cnt));
                check_eq("dut2 pass", 128'(pass2), 128'(e2m.pass));
            end
        end
    end

    // ev: 0 = plain sweep, 1 = stray start pulse at x=20, 2 = reset at x=50.
    task automatic sweep0(input int mode, input int ev);
        fault0 = mode;
        q0.push_back(model(mode, cyc + 129));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check_eq("dut0 x cycle1", 128'(x0), 128'd0);
        check_eq("dut0 busy cycle1", 128'(busy0), 128'd1);
        for (int k = 2; k <= 128; k++) begin
            @(negedge clk);
            start0 = (ev == 1 && k == 21);
            if (ev == 1 && k == 21) check_eq("dut0 x at stray start", 128'(x0), 128'd20);
            if (ev == 2 && k == 51) begin
                check_eq("dut0 x before rst", 128'(x0), 128'd50);
                rst0 = 1'b1;
                @(negedge clk);
                rst0 = 1'b0;
                check_eq("dut0 busy after rst", 128'(busy0), 128'd0);
                check_eq("dut0 x after rst", 128'(x0), 128'd0);
                check_eq("dut0 tt after rst", tt0, 128'd0);
                check_eq("dut0 cnt after rst", 128'(cnt0), 128'd0);
                void'(q0.pop_back());
                @(negedge clk);
                return;
            end
        end
        check_eq("dut0 x cycle128", 128'(x0), 128'd127);
        check_eq("dut0 busy cycle128", 128'(busy0), 128'd1);
        @(negedge clk);
        check_eq("dut0 busy cycle129", 128'(busy0), 128'd0);
        @(negedge clk);
        check_eq("dut0 single done", 128'(done0), 128'd0);
    endtask

    task automatic sweep2();
        q2.push_back(model(0, cyc + 131));
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check_eq("dut2 busy cycle1", 128'(busy2), 128'd1);
        check_eq("dut2 x cycle1", 128'(x2), 128'd0);
        repeat (128) @(negedge clk);
        check_eq("dut2 x drain", 128'(x2), 128'd127);
        check_eq("dut2 busy cycle129", 128'(busy2), 128'd1);
        @(negedge clk);
        check_eq("dut2 busy cycle130", 128'(busy2), 128'd1);
        @(negedge clk);
        check_eq("dut2 busy cycle131", 128'(busy2), 128'd0);
        @(negedge clk);
        check_eq("dut2 single done", 128'(done2), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst0   = 1'b1;
        rst2   = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst2 = 1'b0;
        check_eq("reset x", 128'(x0), 128'd0);
        check_eq("reset busy", 128'(busy0), 128'd0);
        check_eq("reset done", 128'(done0), 128'd0);
        check_eq("reset pass", 128'(pass0), 128'd0);
        check_eq("reset tt", tt0, 128'd0);
        check_eq("reset cnt", 128'(cnt0), 128'd0);
        check_eq("reset ffi", 128'(ffi0), 128'd0);
        check_eq("reset busy dut2", 128'(busy2), 128'd0);

        sweep0(0, 0);
        sweep0(1, 0);
        sweep0(2, 0);
        sweep0(0, 2);
        sweep0(0, 0);
        sweep0(0, 1);

        // start tied high: two back-to-back sweeps with dones 130 cycles apart
        fault0 = 0;
        q0.push_back(model(0, cyc + 129));
        q0.push_back(model(0, cyc + 259));
        start0 = 1'b1;
        repeat (260) @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("dut0 idle after tied start", 128'(busy0), 128'd0);

        sweep2();

        repeat (10) @(negedge clk);
        check_eq("dut0 scoreboard drained", 128'(q0.size()), 128'd0);
        check_eq("dut2 scoreboard drained", 128'(q2.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
